// File: rtl/irq_gateway_arb.sv
// Interrupt gateway and priority arbiter.
// Each source has a level-sensitive gateway that latches one request into
// pending and then ignores the line until the handler completes that ID.
// The arbiter registers the best eligible source every cycle. The handler
// claims that source, which moves it from pending to in-service.
//
// Gateway FSM (one instance per source)
//   state    | meaning
//   GW_READY | idle; a high src_irq at the edge latches pending
//   GW_BUSY  | request latched or in service; src_irq ignored until complete
module irq_gateway_arb #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [N_SRC-1:0]  src_irq,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_addr,
    input  logic [PRIO_W:0]   cfg_wdata,
    input  logic              claim_req,
    output logic              claim_vld,
    output logic [3:0]        claim_id,
    input  logic              complete_req,
    input  logic [3:0]        complete_id,
    output logic              ext_irq
);

    typedef enum logic {
        GW_READY = 1'b0,
        GW_BUSY  = 1'b1
    } gw_state_t;

    gw_state_t         gw_q [N_SRC];
    gw_state_t         gw_d [N_SRC];

    logic [N_SRC-1:0]  pending_q;
    logic [N_SRC-1:0]  pending_d;
    logic [N_SRC-1:0]  in_svc_q;
    logic [N_SRC-1:0]  in_svc_d;
    logic [N_SRC-1:0]  enable_q;
    logic [PRIO_W-1:0] prio_q [N_SRC];
    logic [PRIO_W-1:0] thresh_q;

    logic [3:0]        best_id_q;
    logic [3:0]        best_id_d;
    logic [PRIO_W-1:0] best_prio_q;
    logic [PRIO_W-1:0] best_prio_d;

    logic [N_SRC-1:0]  claim_clr;
    logic [N_SRC-1:0]  cmpl_hit;
    logic [N_SRC-1:0]  pend_arb;

    // Decode the claim and complete strobes into per-source one-hot hits.
    // A complete only counts when the named source is actually in service,
    // so ID 0, out-of-range IDs and stale IDs fall out naturally.
    always_comb begin
        claim_clr = '0;
        cmpl_hit  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            claim_clr[i] = claim_req && (best_id_q == 4'(i + 1));
            cmpl_hit[i]  = complete_req && (complete_id == 4'(i + 1)) && in_svc_q[i];
        end
    end

    // Gateway next state plus the pending and in-service updates it drives.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            gw_d[i] = gw_q[i];
            case (gw_q[i])
                GW_READY: if (src_irq[i]) gw_d[i] = GW_BUSY;
                GW_BUSY:  if (cmpl_hit[i]) gw_d[i] = GW_READY;
                default:  gw_d[i] = GW_READY;
            endcase
        end
        pending_d = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pending_d[i] = (pending_q[i] & ~claim_clr[i])
                         | ((gw_q[i] == GW_READY) & src_irq[i]);
        end
        // A pending source cannot also be in service, so set and clear never collide.
        in_svc_d = (in_svc_q | claim_clr) & ~cmpl_hit;
    end

    // Arbitration sees this edge's claim clear but not this edge's new
    // requests, which gives the one-cycle pending-to-ext_irq latency and
    // guarantees a claimed ID is never offered twice.
    always_comb begin
        pend_arb    = pending_q & ~claim_clr;
        best_id_d   = '0;
        best_prio_d = '0;
        for (int i = 0; i < N_SRC; i++) begin
            // Strict greater-than while scanning upward keeps the lowest ID on ties.
            if (pend_arb[i] && enable_q[i] && (prio_q[i] > thresh_q)
                && (prio_q[i] > best_prio_d)) begin
                best_id_d   = 4'(i + 1);
                best_prio_d = prio_q[i];
            end
        end
    end

    // Gateway state, pending and in-service registers.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < N_SRC; i++) gw_q[i] <= GW_READY;
            pending_q <= '0;
            in_svc_q  <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) gw_q[i] <= gw_d[i];
            pending_q <= pending_d;
            in_svc_q  <= in_svc_d;
        end
    end

    // Configuration register file: address 0 is the threshold, 1..N_SRC are
    // per-source enable and priority; other addresses are dropped.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            enable_q <= '0;
            thresh_q <= '0;
            for (int i = 0; i < N_SRC; i++) prio_q[i] <= '0;
        end else if (cfg_wr) begin
            if (cfg_addr == 4'd0) begin
                thresh_q <= cfg_wdata[PRIO_W-1:0];
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (cfg_addr == 4'(i + 1)) begin
                    enable_q[i] <= cfg_wdata[PRIO_W];
                    prio_q[i]   <= cfg_wdata[PRIO_W-1:0];
                end
            end
        end
    end

    // Registered arbitration result, interrupt request and claim response.
    // A claim returns the winner held before the edge, so a config write
    // in the same cycle cannot change what is handed out.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            best_id_q   <= '0;
            best_prio_q <= '0;
            ext_irq     <= 1'b0;
            claim_vld   <= 1'b0;
            claim_id    <= '0;
        end else begin
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            ext_irq     <= (best_id_d != 4'd0);
            claim_vld   <= claim_req;
            claim_id    <= claim_req ? best_id_q : 4'd0;
        end
    end

    // best_prio is kept registered alongside best_id for visibility; fold it
    // into a signal so the register is not flagged as unused.
    logic best_prio_unused;
    assign best_prio_unused = ^best_prio_q;

endmodule

// File: tb/tb_irq_gateway_arb.sv
// Directed bench for irq_gateway_arb with a claim scoreboard.
module tb_irq_gateway_arb;

    localparam int N_SRC  = 8;
    localparam int PRIO_W = 3;

    logic              clk_in;
    logic              reset_in;
    logic [N_SRC-1:0]  src_irq;
    logic              cfg_wr;
    logic [3:0]        cfg_addr;
    logic [PRIO_W:0]   cfg_wdata;
    logic              claim_req;
    logic              claim_vld;
    logic [3:0]        claim_id;
    logic              complete_req;
    logic [3:0]        complete_id;
    logic              ext_irq;

    int errors = 0;
    int checks = 0;
    int unsigned exp_q[$];

    irq_gateway_arb #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .src_irq      (src_irq),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .claim_req    (claim_req),
        .claim_vld    (claim_vld),
        .claim_id     (claim_id),
        .complete_req (complete_req),
        .complete_id  (complete_id),
        .ext_irq      (ext_irq)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample 1 time unit after the edge, score any claim response,
    // then drop the single-cycle strobes.
    task automatic tick();
        logic drove;
        int unsigned e;
        drove = claim_req;
        @(posedge clk_in);
        #1;
        chk("claim_vld", {31'd0, claim_vld}, {31'd0, drove});
        if (claim_vld && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("claim_id", {28'd0, claim_id}, e);
        end
        cfg_wr       = 1'b0;
        claim_req    = 1'b0;
        complete_req = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] addr, input logic [PRIO_W:0] data);
        cfg_wr    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
    endtask

    task automatic claim(input int unsigned exp_id);
        exp_q.push_back(exp_id);
        claim_req = 1'b1;
        tick();
    endtask

    task automatic complete(input logic [3:0] id);
        complete_req = 1'b1;
        complete_id  = id;
        tick();
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, ext_irq}, {31'd0, exp});
    endtask

    initial begin
        reset_in     = 1'b0;
        src_irq      = '0;
        cfg_wr       = 1'b0;
        cfg_addr     = '0;
        cfg_wdata    = '0;
        claim_req    = 1'b0;
        complete_req = 1'b0;
        complete_id  = '0;

        // Reset state
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        chk("rst_ext_irq", {31'd0, ext_irq}, 0);
        chk("rst_claim_vld", {31'd0, claim_vld}, 0);
        chk("rst_claim_id", {28'd0, claim_id}, 0);
        reset_in = 1'b1;

        // Basic flow: src 3 prio 5, threshold 0
        cfg(4'd3, 4'b1101);
        cfg(4'd0, 4'd0);
        src_irq[2] = 1'b1;
        tick();
        chk_irq("basic_edge1", 1'b0);
        src_irq[2] = 1'b0;
        tick();
        chk_irq("basic_edge2", 1'b1);
        claim(3);
        chk_irq("basic_after_claim", 1'b0);
        complete(4'd3);
        chk_irq("basic_after_cmpl", 1'b0);

        // Priority and ties: src2 p4, src5 p6, src6 p6
        cfg(4'd2, 4'b1100);
        cfg(4'd5, 4'b1110);
        cfg(4'd6, 4'b1110);
        src_irq = 8'b0011_0010;
        tick();
        src_irq = '0;
        tick();
        chk_irq("prio_pending", 1'b1);
        claim(5);
        chk_irq("prio_after5", 1'b1);
        claim(6);
        chk_irq("prio_after6", 1'b1);
        claim(2);
        chk_irq("prio_after2", 1'b0);
        claim(0);
        complete(4'd5);
        complete(4'd6);
        complete(4'd2);

        // Gateway blocking on src 1
        cfg(4'd1, 4'b1001);
        src_irq[0] = 1'b1;
        tick();
        tick();
        chk_irq("gw_first", 1'b1);
        claim(1);
        chk_irq("gw_claimed", 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_irq("gw_blocked", 1'b0);
        end
        complete(4'd1);
        chk_irq("gw_cmpl_edge", 1'b0);
        tick();
        chk_irq("gw_repend_edge", 1'b0);
        tick();
        chk_irq("gw_irq_again", 1'b1);
        claim(1);
        src_irq[0] = 1'b0;
        complete(4'd1);

        // Threshold on src 4 prio 3
        cfg(4'd4, 4'b1011);
        src_irq[3] = 1'b1;
        tick();
        src_irq[3] = 1'b0;
        tick();
        chk_irq("thr_base", 1'b1);
        cfg(4'd0, 4'd3);
        chk_irq("thr3_write_edge", 1'b1);
        tick();
        chk_irq("thr3", 1'b0);
        cfg(4'd0, 4'd2);
        chk_irq("thr2_write_edge", 1'b0);
        tick();
        chk_irq("thr2", 1'b1);
        claim(4);
        complete(4'd4);

        // Disable keeps pending; bad completes; simultaneous claim/complete
        cfg(4'd7, 4'b1101);
        src_irq[6] = 1'b1;
        tick();
        src_irq[6] = 1'b0;
        tick();
        chk_irq("src7_pend", 1'b1);
        cfg(4'd7, 4'b0101);
        tick();
        chk_irq("src7_disabled", 1'b0);
        cfg(4'd7, 4'b1101);
        tick();
        chk_irq("src7_reenabled", 1'b1);
        complete(4'd7);
        chk_irq("bad_cmpl7", 1'b1);
        complete(4'd0);
        chk_irq("bad_cmpl0", 1'b1);
        complete(4'd15);
        chk_irq("bad_cmpl15", 1'b1);
        claim(7);
        chk_irq("src7_claimed", 1'b0);
        src_irq[3] = 1'b1;
        tick();
        src_irq[3] = 1'b0;
        tick();
        chk_irq("src4_pend", 1'b1);
        exp_q.push_back(4);
        claim_req    = 1'b1;
        complete_req = 1'b1;
        complete_id  = 4'd7;
        tick();
        chk_irq("simul_claim", 1'b0);
        src_irq[6] = 1'b1;
        tick();
        src_irq[6] = 1'b0;
        tick();
        chk_irq("simul_cmpl_applied", 1'b1);
        claim(7);
        complete(4'd7);
        complete(4'd4);

        // Async reset while ID 1 is in service mid-claim
        cfg(4'd0, 4'd0);
        src_irq[0] = 1'b1;
        tick();
        tick();
        chk_irq("rst_pre_irq", 1'b1);
        claim_req = 1'b1;
        @(posedge clk_in);
        #1;
        chk("rst_pre_vld", {31'd0, claim_vld}, 1);
        chk("rst_pre_id", {28'd0, claim_id}, 1);
        claim_req = 1'b0;
        #2;
        reset_in = 1'b0;
        #1;
        chk("async_ext_irq", {31'd0, ext_irq}, 0);
        chk("async_claim_vld", {31'd0, claim_vld}, 0);
        chk("async_claim_id", {28'd0, claim_id}, 0);
        @(posedge clk_in);
        #1;
        reset_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_irq("post_rst_quiet", 1'b0);
        end
        claim(0);
        chk("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_gateway_arb.md
IRQ_GATEWAY_ARB -- requirements
Module: irq_gateway_arb

Interface
REQ-001 Parameter N_SRC, default 8: number of external interrupt sources, legal range 1..15; source IDs are 1..N_SRC, and ID 0 means "none".
REQ-002 Parameter PRIO_W, default 3: priority width; priority 0 means never interrupt.
REQ-003 clk_in  input  1: the single clock; all state updates on the rising edge.
REQ-004 reset_in  input  1: asynchronous, active-low reset.
REQ-005 src_irq  input  N_SRC: level-sensitive interrupt lines; bit i-1 is source ID i.
REQ-006 cfg_wr  input  1: configuration write strobe, one cycle per write.
REQ-007 cfg_addr  input  4: configuration address; 0 selects the threshold, 1..N_SRC select a source, all other values are ignored.
REQ-008 cfg_wdata  input  PRIO_W+1: for addr 0, [PRIO_W-1:0] is the threshold; for a source address, [PRIO_W] is the enable and [PRIO_W-1:0] is the priority.
REQ-009 claim_req  input  1: handler claim strobe.
REQ-010 claim_vld  output  1: one-cycle pulse marking claim_id valid.
REQ-011 claim_id  output  4: claimed source ID, or 0 if nothing was claimable.
REQ-012 complete_req  input  1: handler completion strobe.
REQ-013 complete_id  input  4: ID being completed.
REQ-014 ext_irq  output  1: registered machine/supervisor external interrupt request; drives the ext_irq input of the CPU interrupt/mode logic.

Function
REQ-015 Each source has a two-state gateway: READY and BUSY.
REQ-016 READY with src_irq high at an edge: set pending[i] and move to BUSY; this happens whether or not the source is enabled.
REQ-017 BUSY: further src_irq activity is ignored; the gateway returns to READY only on a complete_req naming that ID while it is in service.
REQ-018 The arbiter is eligible for source i only when pending[i]=1, enable[i]=1 and prio[i] > threshold (strictly greater).
REQ-019 Winner selection: highest priority wins; among equal priorities, the lowest ID wins.
REQ-020 best_id and best_prio are registered every edge; if no source is eligible, best_id=0 and best_prio=0.
REQ-021 ext_irq is registered and equals (next best_id != 0).
REQ-022 Latency: src_irq sampled high at edge t gives pending at t; ext_irq rises at edge t+1.
REQ-023 Claim: claim_req at edge t sets claim_vld=1 and claim_id=best_id (value held before edge t), clears pending[best_id] and sets in_service[best_id].
REQ-024 A claim with best_id=0 still pulses claim_vld, with claim_id=0 and no state change.
REQ-025 The arbitration registered at edge t uses pending after that edge's claim clear, so a claimed ID is never presented twice.
REQ-026 Complete: complete_req with in_service[complete_id]=1 clears in_service and returns that gateway to READY.
REQ-027 A complete with an ID that is 0, out of range or not in service is ignored.
REQ-028 Claim and complete in the same cycle are both applied.
REQ-029 If the completed ID's src_irq is still high at the completion edge, the gateway goes READY at that edge and re-pends at the next edge.
REQ-030 A config write takes effect at its edge; the changed priority, enable or threshold affects the arbitration registered at the following edge.
REQ-031 Disabling a pending source keeps it pending but makes it ineligible.
REQ-032 A config write and a claim in the same cycle: the claim uses the pre-write best_id.

Reset
REQ-033 Asserting reset_in low, at any time including mid-claim, immediately clears pending, in_service, enable, prio, threshold, best_id, best_prio, ext_irq, claim_vld and claim_id, and sets every gateway to READY.
REQ-034 After reset release, nothing interrupts until software has written an enable and a nonzero priority.

Verification
REQ-035 Basic flow: enable src 3 with prio 5, threshold 0, pulse src_irq[2] -> ext_irq=1 two edges later; claim -> claim_id=3, ext_irq=0 at the next edge.
REQ-036 Priority and ties: src 2 prio 4, src 5 prio 6, src 6 prio 6 all pending -> three claims return 5, then 6, then 2; a fourth claim returns claim_id=0.
REQ-037 Gateway blocking: hold src_irq[0] high after claiming ID 1 -> no re-pend while in service; complete ID 1 -> pending again one edge later and ext_irq=1 the edge after.
REQ-038 Threshold: src 4 prio 3 pending, threshold written to 3 -> ext_irq=0; threshold written to 2 -> ext_irq=1.
REQ-039 Bad completes and simultaneous events: complete ID 7 when it is not in service -> no change; claim and complete in the same cycle -> both applied.
REQ-040 Async reset: drive reset_in low mid-cycle while ID 1 is in service -> all outputs 0 immediately; after release, with src_irq held high, ext_irq stays 0.
